seg_disp_ctrl: RTL

Content controller for the 4-digit seven-segment scanner. It accepts a 14-bit binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 engine. It then applies leading-zero blanking and decimal-point insertion, encodes each digit to an active-low segment pattern, and holds the four patterns stable on `k_num`/`h_num`/`d_num`/`u_num` for the scanner to multiplex.

---
 rtl/seg_disp_ctrl_if.sv | 27 ++
 rtl/seg_disp_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg_disp_ctrl_if.sv
// Value handshake and segment-pattern bundle between a producer and seg_disp_ctrl.
// The producer takes the master modport; the controller takes the slave modport.
interface seg_disp_ctrl_if #(
   parameter int unsigned BIN_W = 14
);
   logic             in_valid;
   logic [BIN_W-1:0] in_value;
   logic [3:0]       in_dp;
   logic             in_blank;
   logic             in_ready;
   logic             done;
   logic             ovf;
   logic [7:0]       k_num;
   logic [7:0]       h_num;
   logic [7:0]       d_num;
   logic [7:0]       u_num;

   modport master (
      output in_valid, in_value, in_dp, in_blank,
      input  in_ready, done, ovf, k_num, h_num, d_num, u_num
   );

   modport slave (
      input  in_valid, in_value, in_dp, in_blank,
      output in_ready, done, ovf, k_num, h_num, d_num, u_num
   );
endinterface

// File: rtl/seg_disp_ctrl.sv
// Four-digit seven-segment content controller: sequential shift-add-3 binary-to-BCD,
// leading-zero blanking, decimal points and active-low encoding held for the scanner.
module seg_disp_ctrl #(
   parameter int unsigned BIN_W = 14
) (
   input logic            clk,
   input logic            rst,
   seg_disp_ctrl_if.slave bus
);

   localparam int unsigned ShW     = 16 + BIN_W;
   localparam int unsigned MaxDisp = 9999;

   typedef enum logic [1:0] {StIdle, StConv, StEnc} state_e;

   state_e         state_q;
   logic [ShW-1:0] sh_q;
   logic [3:0]     cnt_q;
   logic [3:0]     dp_q;
   logic           blank_q;
   logic           big_q;

   logic [15:0]    bcd_adj;
   logic [ShW-1:0] sh_shift;
   logic [3:0]     dig [4];
   logic [7:0]     pat [4];
   logic [3:0]     lz;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Nibbles >= 5 get +3 before the shift; the bound keeps each nibble <= 12, so no carry.
   always_comb begin
      bcd_adj = sh_q[ShW-1:BIN_W];
      for (int i = 0; i < 4; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
         end
      end
      sh_shift = {bcd_adj[14:0], sh_q[BIN_W-1:0], 1'b0};
   end

   // Index 3 = thousands ... 0 = units; lz[i] marks digit i as a blankable leading zero.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dig[i] = sh_q[BIN_W + 4*i +: 4];
      end
      lz[3] = blank_q && (dig[3] == 4'd0) && !dp_q[3];
      lz[2] = lz[3] && (dig[2] == 4'd0) && !dp_q[2];
      lz[1] = lz[2] && (dig[1] == 4'd0) && !dp_q[1];
      lz[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (big_q) begin
            pat[i] = 8'hBF;
         end else if (lz[i]) begin
            pat[i] = 8'hFF;
         end else begin
            pat[i] = seg7(dig[i]);
         end
         pat[i][7] = pat[i][7] & ~dp_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         sh_q         <= '0;
         cnt_q        <= 4'd0;
         dp_q         <= 4'd0;
         blank_q      <= 1'b0;
         big_q        <= 1'b0;
         bus.in_ready <= 1'b1;
         bus.done     <= 1'b0;
         bus.ovf      <= 1'b0;
         bus.k_num    <= 8'hFF;
         bus.h_num    <= 8'hFF;
         bus.d_num    <= 8'hFF;
         bus.u_num    <= 8'hFF;
      end else begin
         bus.done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.in_valid && bus.in_ready) begin
                  sh_q         <= {16'd0, bus.in_value};
                  cnt_q        <= 4'(BIN_W - 1);
                  dp_q         <= bus.in_dp;
                  blank_q      <= bus.in_blank;
                  big_q        <= 32'(bus.in_value) > MaxDisp;
                  bus.in_ready <= 1'b0;
                  state_q      <= StConv;
               end
            end
            StConv: begin
               sh_q <= sh_shift;
               if (cnt_q == 4'd0) begin
                  state_q <= StEnc;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StEnc: begin
               bus.k_num    <= pat[3];
               bus.h_num    <= pat[2];
               bus.d_num    <= pat[1];
               bus.u_num    <= pat[0];
               bus.ovf      <= big_q;
               bus.done     <= 1'b1;
               bus.in_ready <= 1'b1;
               state_q      <= StIdle;
            end
            default: begin
               state_q      <= StIdle;
               bus.in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
